// File: rtl/gcd_job_driver_if.sv
// Interface bundling the job request/response handshakes and the GCD core pins.
// The slave modport is the driver's view; the master modport is the job source plus core side.
interface gcd_job_driver_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_a;
  logic [WIDTH-1:0] rsp_b;
  logic [WIDTH-1:0] rsp_gcd;
  logic             rsp_err;
  logic             gcd_rst;
  logic             gcd_go;
  logic [WIDTH-1:0] gcd_in1;
  logic [WIDTH-1:0] gcd_in2;
  logic [WIDTH-1:0] gcd_out;
  logic             gcd_done;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, gcd_out, gcd_done,
    output req_ready, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_err,
           gcd_rst, gcd_go, gcd_in1, gcd_in2
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready, gcd_out, gcd_done,
    input  req_ready, rsp_valid, rsp_a, rsp_b, rsp_gcd, rsp_err,
           gcd_rst, gcd_go, gcd_in1, gcd_in2
  );
endinterface

// File: rtl/gcd_job_driver.sv
// Initiator-side controller for one GCD core: accepts a job, sequences reset/go, returns the result.
// Optional done-timeout is compiled in with `define GCD_DRV_TIMEOUT_EN.
module gcd_job_driver #(
  parameter int WIDTH     = 32,
  parameter int GO_CYCLES = 2,
  parameter int TIMEOUT   = 4096
) (
  input logic             clk,
  input logic             rst,
  gcd_job_driver_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CRST,
    GO,
    WAIT,
    RESP
  } state_e;

  localparam int GO_W = (GO_CYCLES > 1) ? $clog2(GO_CYCLES) : 1;

  state_e            state_q, state_d;
  logic [GO_W-1:0]   go_cnt_q, go_cnt_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              rsp_valid_q;
  logic              gcd_rst_q;
  logic              gcd_go_q;

`ifdef GCD_DRV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
`endif

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    go_cnt_d = go_cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    res_d    = res_q;
`ifdef GCD_DRV_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_a_d = bus.req_a;
          op_b_d = bus.req_b;
`ifdef GCD_DRV_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          // gcd(x,0) = x and gcd(0,0) = 0, so a zero operand never needs the core.
          if (bus.req_a == '0 || bus.req_b == '0) begin
            res_d   = bus.req_a | bus.req_b;
            state_d = RESP;
          end else begin
            state_d = CRST;
          end
        end
      end

      CRST: begin
        go_cnt_d = '0;
        state_d  = GO;
      end

      GO: begin
`ifdef GCD_DRV_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (go_cnt_q == GO_W'(GO_CYCLES - 1)) begin
          state_d = WAIT;
        end else begin
          go_cnt_d = go_cnt_q + 1'b1;
        end
      end

      WAIT: begin
        // A done coinciding with counter expiry still wins, so it is tested first.
        if (bus.gcd_done) begin
          res_d   = bus.gcd_out;
          state_d = RESP;
`ifdef GCD_DRV_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wait_cnt_q == TO_W'(TIMEOUT)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      go_cnt_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      res_q       <= '0;
      rsp_valid_q <= 1'b0;
      gcd_rst_q   <= 1'b0;
      gcd_go_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_cnt_q    <= go_cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      res_q       <= res_d;
      rsp_valid_q <= (state_d == RESP);
      gcd_rst_q   <= (state_d == CRST);
      gcd_go_q    <= (state_d == GO);
    end
  end

`ifdef GCD_DRV_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  assign bus.rsp_err = err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_a     = op_a_q;
  assign bus.rsp_b     = op_b_q;
  assign bus.rsp_gcd   = res_q;
  assign bus.gcd_rst   = gcd_rst_q;
  assign bus.gcd_go    = gcd_go_q;
  assign bus.gcd_in1   = op_a_q;
  assign bus.gcd_in2   = op_b_q;

endmodule

// File: tb/tb_gcd_job_driver.sv
// Bench for gcd_job_driver: behavioural GCD core, job-level reference model, directed jobs.
// Timeout expectations follow whether GCD_DRV_TIMEOUT_EN is defined for the build.
module tb_gcd_job_driver;

  localparam int WIDTH     = 32;
  localparam int GO_CYCLES = 2;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst;

  gcd_job_driver_if #(.WIDTH(WIDTH)) bus ();

  gcd_job_driver #(
    .WIDTH    (WIDTH),
    .GO_CYCLES(GO_CYCLES),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] gcd_fn(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, t;
    a = x;
    b = y;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Behavioural core: done is a level that drops on reset/go and rises core_lat cycles after go.
  bit sticky_done = 1'b0;
  bit core_mute   = 1'b0;
  int core_lat    = 3;
  int core_cnt;
  bit core_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.gcd_done <= 1'b0;
      bus.gcd_out  <= '0;
      core_cnt     <= 0;
      core_busy    <= 1'b0;
    end else if (bus.gcd_rst && !sticky_done) begin
      bus.gcd_done <= 1'b0;
      core_busy    <= 1'b0;
    end else if (bus.gcd_go) begin
      bus.gcd_done <= 1'b0;
      core_busy    <= 1'b1;
      core_cnt     <= core_lat;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy <= 1'b0;
        if (!core_mute) begin
          bus.gcd_done <= 1'b1;
          bus.gcd_out  <= gcd_fn(bus.gcd_in1, bus.gcd_in2);
        end
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  // Job-level model: one outstanding job, expected response computed from the operands.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] g;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  bit   exp_idle = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_idle = 1'b1;
    end else if (exp_idle && bus.req_valid) begin
      exp_t e;
      e.a   = bus.req_a;
      e.b   = bus.req_b;
      e.err = 1'b0;
      if (bus.req_a == 0 || bus.req_b == 0) begin
        e.g = bus.req_a | bus.req_b;
      end else if (core_mute) begin
        e.g   = 0;
        e.err = 1'b1;
      end else begin
        e.g = gcd_fn(bus.req_a, bus.req_b);
      end
      exp_q.push_back(e);
      exp_idle = 1'b0;
    end else if (!exp_idle && bus.rsp_valid && bus.rsp_ready) begin
      void'(exp_q.pop_front());
      exp_idle = 1'b1;
    end
  end

  bit mon_en = 1'b0;

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      check("req_ready_vs_model", bus.req_ready, exp_idle);
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_valid_without_job", bus.rsp_valid, 0);
        end else begin
          check("model_rsp_a", bus.rsp_a, exp_q[0].a);
          check("model_rsp_b", bus.rsp_b, exp_q[0].b);
          check("model_rsp_gcd", bus.rsp_gcd, exp_q[0].g);
          check("model_rsp_err", bus.rsp_err, exp_q[0].err);
        end
      end
      if ((bus.gcd_rst || bus.gcd_go) && exp_q.size() != 0) begin
        check("model_gcd_in1", bus.gcd_in1, exp_q[0].a);
        check("model_gcd_in2", bus.gcd_in2, exp_q[0].b);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_a"}, bus.rsp_a, 0);
    check({tag, "_rsp_b"}, bus.rsp_b, 0);
    check({tag, "_rsp_gcd"}, bus.rsp_gcd, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_gcd_rst"}, bus.gcd_rst, 0);
    check({tag, "_gcd_go"}, bus.gcd_go, 0);
    check({tag, "_gcd_in1"}, bus.gcd_in1, 0);
    check({tag, "_gcd_in2"}, bus.gcd_in2, 0);
  endtask

  // Returns at the first negedge after the accepting edge (cycle N+1).
  task automatic send_req(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    for (int t = 0; t < 50 && !bus.req_ready; t++) @(negedge clk);
    check("req_ready_before_send", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g,
                         input bit bypass, input int hold, input bit err, input int wait_lat);
    int rst_first, rst_cnt, go_first, go_last, go_cnt, wait_at, rsp_at;
    rst_first = -1; rst_cnt = 0; go_first = -1; go_last = -1; go_cnt = 0;
    wait_at = -1; rsp_at = -1;
    send_req(a, b);
    for (int t = 1; t <= 300; t++) begin
      if (bus.gcd_rst) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = t;
      end
      if (bus.gcd_go) begin
        go_cnt++;
        if (go_first < 0) go_first = t;
        go_last = t;
      end else if (go_first >= 0 && wait_at < 0) begin
        wait_at = t;
      end
      if (bus.rsp_valid) begin
        rsp_at = t;
        break;
      end
      @(negedge clk);
    end
    check("rsp_within_budget", rsp_at > 0, 1);
    if (rsp_at < 0) return;
    check("rsp_gcd", bus.rsp_gcd, g);
    check("rsp_a", bus.rsp_a, a);
    check("rsp_b", bus.rsp_b, b);
    check("rsp_err", bus.rsp_err, err);
    if (bypass) begin
      check("bypass_rsp_cycle", rsp_at, 1);
      check("bypass_no_gcd_rst", rst_cnt, 0);
      check("bypass_no_gcd_go", go_cnt, 0);
    end else begin
      check("gcd_rst_cycle", rst_first, 1);
      check("gcd_rst_width", rst_cnt, 1);
      check("gcd_go_first", go_first, 2);
      check("gcd_go_last", go_last, 1 + GO_CYCLES);
      check("gcd_go_width", go_cnt, GO_CYCLES);
    end
    if (wait_lat >= 0) check("wait_entry_to_rsp", rsp_at - wait_at, wait_lat);
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", bus.rsp_valid, 1);
      check("hold_rsp_gcd", bus.rsp_gcd, g);
      check("hold_rsp_a", bus.rsp_a, a);
      check("hold_req_ready", bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("req_ready_after_hs", bus.req_ready, 1);
    check("rsp_valid_after_hs", bus.rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst    = 1'b0;
    mon_en = 1'b1;

    // Basic job through the core.
    run_job(48, 18, 6, 0, 0, 0, -1);

    // Back-to-back; job 2 sees stale done=1 (value 45) during CRST and the first GO cycle.
    run_job(45, 90, 45, 0, 0, 0, -1);
    sticky_done = 1'b1;
    run_job(35, 49, 7, 0, 0, 0, -1);
    sticky_done = 1'b0;

    // Zero-operand bypass.
    run_job(0, 35, 35, 1, 0, 0, -1);
    run_job(0, 0, 0, 1, 0, 0, -1);
    run_job(21, 0, 21, 1, 0, 0, -1);

    // Consumer back-pressure for 10 cycles.
    run_job(2000, 10000, 2000, 0, 10, 0, -1);

    // Core that never finishes.
    core_mute = 1'b1;
`ifdef GCD_DRV_TIMEOUT_EN
    run_job(9, 6, 0, 0, 0, 1, TIMEOUT + 1);
`else
    send_req(9, 6);
    n = 0;
    repeat (1000) begin
      if (bus.rsp_valid) n++;
      @(negedge clk);
    end
    check("no_rsp_without_timeout", n, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    core_mute = 1'b0;

    // Async reset in the middle of WAIT.
    core_lat = 30;
    send_req(48123, 628163);
    for (int t = 0; t < 20 && !bus.gcd_go; t++) @(negedge clk);
    for (int t = 0; t < 20 && bus.gcd_go; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("wait_no_rsp_yet", bus.rsp_valid, 0);
    check("wait_gcd_in1", bus.gcd_in1, 48123);
    check("wait_gcd_in2", bus.gcd_in2, 628163);
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) n++;
    end
    check("no_rsp_after_rst", n, 0);
    core_lat = 3;
    run_job(12, 8, 4, 0, 0, 0, -1);

    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gcd_job_driver.md
# gcd_job_driver

Initiator-side controller for the GCD core. Accepts operand pairs on a valid/ready request port, sequences the core's reset/go/in1/in2 pins, waits for `done`, and returns the captured result on a valid/ready response port. It sits between any job source (CPU bridge, FIFO, bench sequencer) and one GCD core instance. It replaces hand-driven go/reset sequencing.

## Interface
- `WIDTH`, 32, operand/result width
- `GO_CYCLES`, 2, cycles `gcd_go` is held high per job (≥1)
- `TIMEOUT`, 4096, max cycles waited for `gcd_done` (used only with timeout compiled in)

- `clk` in 1 — single clock, all logic on posedge
- `rst` in 1 — asynchronous, active-high reset
- `req_valid` in 1 — request operands valid
- `req_ready` out 1 — driver can accept a request
- `req_a` in WIDTH — first operand
- `req_b` in WIDTH — second operand
- `rsp_valid` out 1 — response valid
- `rsp_ready` in 1 — consumer accepts response
- `rsp_a` out WIDTH — echo of accepted `req_a`
- `rsp_b` out WIDTH — echo of accepted `req_b`
- `rsp_gcd` out WIDTH — result
- `rsp_err` out 1 — job timed out (0 when timeout not compiled)
- `gcd_rst` out 1 — synchronous reset pulse to core
- `gcd_go` out 1 — core start
- `gcd_in1` out WIDTH — core operand 1
- `gcd_in2` out WIDTH — core operand 2
- `gcd_out` in WIDTH — core result
- `gcd_done` in 1 — core done, level

## Operation
- States: IDLE, CRST, GO, WAIT, RESP.
- IDLE: `req_ready=1`. On `req_valid && req_ready`, latch a/b into operand registers.
  - If `a==0` or `b==0`: result = a|b (gcd(x,0)=x, gcd(0,0)=0), go to RESP, core untouched.
  - Otherwise go to CRST.
- CRST: `gcd_rst=1` for exactly one cycle, then GO.
- GO: `gcd_go=1` for GO_CYCLES cycles, then WAIT. `gcd_done` ignored in CRST/GO (stale done from previous job).
- WAIT: on first cycle `gcd_done==1`, capture `gcd_out` into `rsp_gcd`, `rsp_err=0`, go to RESP.
- RESP: `rsp_valid=1`; rsp_* held stable until `rsp_valid && rsp_ready`, then IDLE.
- `gcd_in1`/`gcd_in2` driven from operand registers, stable from CRST through WAIT and unchanged until next accepted request.
- `req_ready` is 0 in every state except IDLE; no request overlap, no queueing.

## Timing
- Reset values: `req_ready=1` (IDLE), `rsp_valid=0`, `rsp_a/rsp_b/rsp_gcd=0`, `rsp_err=0`, `gcd_rst=0`, `gcd_go=0`, `gcd_in1/gcd_in2=0`.
- Request accepted at edge N: `gcd_rst` high in cycle N+1. `gcd_go` high in cycles N+2 .. N+1+GO_CYCLES. WAIT starts at N+2+GO_CYCLES.
- `gcd_done` sampled high at edge M: `rsp_valid` high from cycle M+1.
- Bypass path: `rsp_valid` high in cycle N+1.
- Response handshake at edge K: `req_ready` high in cycle K+1. No same-cycle turnaround.
- All outputs registered except `req_ready`, which is decoded from state.
- Async `rst` in any state: immediate return to IDLE with reset values. In-flight job discarded, no response. `gcd_rst` deasserts with it.

## Configuration
- `GCD_DRV_TIMEOUT_EN` defined:
  - A cycle counter runs in WAIT, sized to hold TIMEOUT.
  - If TIMEOUT cycles elapse without `gcd_done`, go to RESP with `rsp_err=1`, `rsp_gcd=0`.
  - Done on the same cycle the count expires wins (`rsp_err=0`).
- Undefined: no counter; WAIT persists until `gcd_done`; `rsp_err` tied 0.

## Test plan
- (48,18) with behavioural core, GO_CYCLES=2: `gcd_rst` pulse at N+1, `gcd_go` high N+2..N+3, `rsp_gcd=6`, `rsp_a=48`, `rsp_b=18`, `rsp_err=0`.
- Back-to-back jobs (45,90) then (35,49), core's `done` still high from job 1 during job 2 CRST/GO: responses 45 then 7; stale done not captured.
- (0,35) and (0,0): `rsp_gcd=35`/`0` at N+1; `gcd_go` and `gcd_rst` never assert.
- (2000,10000), `rsp_ready` held low 10 cycles: rsp_* stable with `rsp_gcd=2000` and `req_ready=0` throughout; `req_ready=1` the cycle after the handshake.
- Timeout compiled, TIMEOUT=16, core stub never asserts done: `rsp_valid` with `rsp_err=1`, `rsp_gcd=0` exactly 17 cycles after WAIT entry. Without the macro: no response after 1000 cycles.
- Async `rst` asserted mid-WAIT of (48123,628163): outputs at reset values immediately; no response; next job (12,8) returns 4.
